// File: rtl/decode_vector_checker_if.sv
// Bus bundle between the decode vector checker and whatever drives/observes it.
interface decode_vector_checker_if #(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned CTRL_WIDTH     = 13,
  parameter int unsigned VEC_ADDR_WIDTH = 3,
  parameter int unsigned SETTLE_WIDTH   = 4
);
  logic                      vecWriteEn;
  logic [VEC_ADDR_WIDTH-1:0] vecWriteAddr;
  logic [INSTR_WIDTH-1:0]    vecWriteInstr;
  logic [CTRL_WIDTH-1:0]     vecWriteExpected;
  logic [CTRL_WIDTH-1:0]     vecWriteMask;
  logic [VEC_ADDR_WIDTH:0]   vecCount;
  logic [SETTLE_WIDTH-1:0]   settleCycles;
  logic                      start;
  logic                      abort;
  logic [INSTR_WIDTH-1:0]    instruction;
  logic [CTRL_WIDTH-1:0]     ctrlIn;
  logic                      busy;
  logic                      done;
  logic                      mismatch;
  logic [VEC_ADDR_WIDTH:0]   passCount;
  logic [VEC_ADDR_WIDTH:0]   failCount;
  logic                      firstFailValid;
  logic [VEC_ADDR_WIDTH-1:0] firstFailIndex;

  // Controller / decoder-stub side
  modport master (
    output vecWriteEn, vecWriteAddr, vecWriteInstr, vecWriteExpected, vecWriteMask,
    output vecCount, settleCycles, start, abort, ctrlIn,
    input  instruction, busy, done, mismatch, passCount, failCount,
    input  firstFailValid, firstFailIndex
  );

  // Checker side
  modport slave (
    input  vecWriteEn, vecWriteAddr, vecWriteInstr, vecWriteExpected, vecWriteMask,
    input  vecCount, settleCycles, start, abort, ctrlIn,
    output instruction, busy, done, mismatch, passCount, failCount,
    output firstFailValid, firstFailIndex
  );
endinterface

// File: rtl/decode_vector_checker.sv
// Applies stored instructions to the control decoder, waits a programmable
// settle time, and checks the decoder's packed control outputs under a mask.
module decode_vector_checker #(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned CTRL_WIDTH     = 13,
  parameter int unsigned NUM_VECTORS    = 8,
  parameter int unsigned VEC_ADDR_WIDTH = 3,
  parameter int unsigned SETTLE_WIDTH   = 4
) (
  input logic clk,
  input logic rst,
  decode_vector_checker_if.slave bus
);
  localparam int unsigned CNT_W = VEC_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, COMPARE, DONE} state_t;

  state_t                    state;
  logic [INSTR_WIDTH-1:0]    mem_instr    [NUM_VECTORS];
  logic [CTRL_WIDTH-1:0]     mem_expected [NUM_VECTORS];
  logic [CTRL_WIDTH-1:0]     mem_mask     [NUM_VECTORS];

  logic [VEC_ADDR_WIDTH-1:0] index;
  logic [CNT_W-1:0]          count_q;
  logic [SETTLE_WIDTH-1:0]   settle_q;
  logic [SETTLE_WIDTH-1:0]   settle_cnt;

  logic [INSTR_WIDTH-1:0]    instruction_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      mismatch_q;
  logic [CNT_W-1:0]          pass_q;
  logic [CNT_W-1:0]          fail_q;
  logic                      ff_valid_q;
  logic [VEC_ADDR_WIDTH-1:0] ff_index_q;

  logic                      wr_ok_c;
  logic [CNT_W-1:0]          count_c;
  logic [SETTLE_WIDTH-1:0]   settle_c;
  logic                      fail_c;
  logic                      last_c;
  logic [CNT_W-1:0]          pass_inc_c;
  logic [CNT_W-1:0]          fail_inc_c;

  // Start-time operand conditioning, compare result and saturating increments
  always_comb begin
    wr_ok_c    = bus.vecWriteEn && !busy_q && ({1'b0, bus.vecWriteAddr} < NUM_VEC_C);
    count_c    = (bus.vecCount > NUM_VEC_C) ? NUM_VEC_C : bus.vecCount;
    settle_c   = (bus.settleCycles == '0) ? SETTLE_WIDTH'(1) : bus.settleCycles;
    fail_c     = |((bus.ctrlIn ^ mem_expected[index]) & mem_mask[index]);
    last_c     = (({1'b0, index} + CNT_W'(1)) == count_q);
    pass_inc_c = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
    fail_inc_c = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
  end

  // Vector memory write port; not cleared by reset and frozen during a run
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem_instr[bus.vecWriteAddr]    <= bus.vecWriteInstr;
      mem_expected[bus.vecWriteAddr] <= bus.vecWriteExpected;
      mem_mask[bus.vecWriteAddr]     <= bus.vecWriteMask;
    end
  end

  // Run sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      index         <= '0;
      count_q       <= '0;
      settle_q      <= '0;
      settle_cnt    <= '0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mismatch_q    <= 1'b0;
      pass_q        <= '0;
      fail_q        <= '0;
      ff_valid_q    <= 1'b0;
      ff_index_q    <= '0;
    end else begin
      mismatch_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            count_q    <= count_c;
            settle_q   <= settle_c;
            index      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
            if (count_c == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= APPLY;
              done_q <= 1'b0;
              busy_q <= 1'b1;
            end
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            instruction_q <= mem_instr[index];
            settle_cnt    <= settle_q;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (settle_cnt <= SETTLE_WIDTH'(1)) begin
            state <= COMPARE;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
          end
        end
        COMPARE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (fail_c) begin
              fail_q     <= fail_inc_c;
              mismatch_q <= 1'b1;
              if (!ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_index_q <= index;
              end
            end else begin
              pass_q <= pass_inc_c;
            end
            if (last_c) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              index <= index + VEC_ADDR_WIDTH'(1);
              state <= APPLY;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction    = instruction_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.passCount      = pass_q;
  assign bus.failCount      = fail_q;
  assign bus.firstFailValid = ff_valid_q;
  assign bus.firstFailIndex = ff_index_q;
endmodule
